// File: rtl/data_cache_sa.sv
// data_cache_sa: N-way set-associative, write-through, no-write-allocate data
// cache with one word per line, per-set round-robin (FIFO) victim selection,
// req/ack refill and a single-cycle flush.
// Optional build macro: DATA_CACHE_STATS_EN adds hit/miss counters and stats_clr.
//
// Handshake: the requester raises cpu_req with stable operands and holds them
// until the single-cycle cpu_ready pulse; the cache raises mem_req (with mem_we,
// mem_addr, mem_wdata stable) and holds it until the one-cycle mem_ack, which
// is ignored in any state that is not waiting for it.
module data_cache_sa #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 8,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        dbg_state
`ifdef DATA_CACHE_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  state_t r_state, w_next;

  logic [WAYS-1:0]   r_valid [SETS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [DATA_W-1:0] r_data  [SETS][WAYS];
  logic [PTR_W-1:0]  r_ptr   [SETS];

  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [IDX_W-1:0]  w_idx, w_fidx;
  logic [TAG_W-1:0]  w_tag, w_ftag;
  logic              w_hit, w_accept, w_unused;
  logic [PTR_W-1:0]  w_hit_way, w_victim;

  // Lookup uses the live request; the refill target is recovered from the
  // latched memory address so FILL does not depend on the requester's inputs.
  assign w_idx    = cpu_addr[IDX_W+1:2];
  assign w_tag    = cpu_addr[ADDR_W-1:IDX_W+2];
  assign w_fidx   = r_mem_addr[IDX_W+1:2];
  assign w_ftag   = r_mem_addr[ADDR_W-1:IDX_W+2];
  assign w_victim = r_ptr[w_fidx];
  assign w_accept = (r_state == S_IDLE) && cpu_req && !flush;
  assign w_unused = ^cpu_addr[1:0];

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = (r_state == S_DONE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

  // Parallel tag compare across the ways of the indexed set.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = PTR_W'(w);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = cpu_we ? S_WRITE : (w_hit ? S_DONE : S_FILL);
      S_FILL:  if (mem_ack) w_next = S_DONE;
      S_WRITE: if (mem_ack) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Valid bits, victim pointers and the registered CPU/memory outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
      r_cpu_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) begin
              r_valid[s] <= '0;
              r_ptr[s]   <= '0;
            end
          end else if (cpu_req) begin
            if (!cpu_we && w_hit) begin
              r_cpu_rdata <= r_data[w_idx][w_hit_way];
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= cpu_we;
              r_mem_addr <= {cpu_addr[ADDR_W-1:2], 2'b00};
              if (cpu_we) r_mem_wdata <= cpu_wdata;
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_valid[w_fidx][w_victim] <= 1'b1;
            if (WAYS > 1) r_ptr[w_fidx] <= w_victim + 1'b1;
            r_cpu_rdata <= mem_rdata;
            r_mem_req   <= 1'b0;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays carry no reset; validity is governed by r_valid alone.
  always_ff @(posedge clk) begin
    if (w_accept && cpu_we && w_hit) begin
      r_data[w_idx][w_hit_way] <= cpu_wdata;
    end
    if ((r_state == S_FILL) && mem_ack) begin
      r_tag[w_fidx][w_victim]  <= w_ftag;
      r_data[w_fidx][w_victim] <= mem_rdata;
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // One counter steps per accepted access; clear wins over a same-cycle step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (stats_clr) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_accept) begin
      if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
      else       r_miss_count <= r_miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_sa.sv
// tb_data_cache_sa: directed bench for data_cache_sa with a read-data scoreboard.
module tb_data_cache_sa;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [1:0]  dbg_state;
`ifdef DATA_CACHE_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] hit_count, miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  data_cache_sa dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
`ifdef DATA_CACHE_STATS_EN
    , .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; reads register their expected data.
  task automatic start(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    if (!we) exp_q.push_back(exp_rd);
  endtask

  // Completion cycle: check the pulse, pop the scoreboard, release the request.
  task automatic finish_done(input string tag, input logic is_read);
    chk({tag, "_ready"}, {31'd0, cpu_ready}, 32'd1);
    chk({tag, "_req_low"}, {31'd0, mem_req}, 32'd0);
    if (is_read) begin
      if (exp_q.size() == 0) chk({tag, "_q_empty"}, 32'd0, 32'd1);
      else chk({tag, "_rdata"}, cpu_rdata, exp_q.pop_front());
    end
    cpu_req = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, cpu_ready}, 32'd0);
  endtask

  // Memory side: hold request for three cycles, then ack with refill data.
  task automatic serve_mem(input string tag, input logic is_read, input logic [31:0] refill);
    repeat (2) begin
      @(negedge clk);
      chk({tag, "_req_held"}, {31'd0, mem_req}, 32'd1);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = refill;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    finish_done(tag, is_read);
  endtask

  // Full access: expect_hit applies to reads (a hit completes with no mem_req).
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic expect_hit,
                        input logic [31:0] refill, input logic [31:0] exp_rd);
    start(we, addr, wdata, exp_rd);
    @(negedge clk);
    if (!we && expect_hit) begin
      finish_done(tag, 1'b1);
    end else begin
      chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
      chk({tag, "_mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
      if (we) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
      chk({tag, "_not_ready"}, {31'd0, cpu_ready}, 32'd0);
      serve_mem(tag, !we, refill);
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;

    // Read miss then hit.
    access("rd_miss_40", 1'b0, 32'h40, 32'h0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
    access("rd_hit_40", 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 32'hDEADBEEF);

    // Write-through hit updates the cached word.
    access("wr_hit_40", 1'b1, 32'h40, 32'h12345678, 1'b0, 32'h0, 32'h0);
    access("rd_hit_40b", 1'b0, 32'h43, 32'h0, 1'b1, 32'h0, 32'h12345678);

    // No-write-allocate.
    access("wr_miss_80", 1'b1, 32'h80, 32'hAAAA5555, 1'b0, 32'h0, 32'h0);
    access("rd_miss_80", 1'b0, 32'h80, 32'h0, 1'b0, 32'hAAAA5555, 32'hAAAA5555);

    // FIFO replacement in set 0 from a clean cache.
    do_flush();
    access("rd_miss_40c", 1'b0, 32'h40, 32'h0, 1'b0, 32'hA, 32'hA);
    access("rd_miss_140", 1'b0, 32'h140, 32'h0, 1'b0, 32'hB, 32'hB);
    access("rd_miss_240", 1'b0, 32'h240, 32'h0, 1'b0, 32'hC, 32'hC);
    access("rd_hit_140", 1'b0, 32'h140, 32'h0, 1'b1, 32'h0, 32'hB);
    access("rd_evict_40", 1'b0, 32'h40, 32'h0, 1'b0, 32'hD, 32'hD);
    access("rd_hit_240", 1'b0, 32'h240, 32'h0, 1'b1, 32'h0, 32'hC);

    // Flush wins over a same-cycle request; the request is then a miss.
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    exp_q.push_back(32'hE);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_no_accept_req", {31'd0, mem_req}, 32'd0);
    chk("flush_no_accept_rdy", {31'd0, cpu_ready}, 32'd0);
    chk("flush_state_idle", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    chk("flush_retry_req", {31'd0, mem_req}, 32'd1);
    chk("flush_retry_addr", mem_addr, 32'h40);
    serve_mem("flush_retry", 1'b1, 32'hE);

    // Reset in the middle of a refill.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h240;
    @(negedge clk);
    chk("midfill_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midfill_rst_req", {31'd0, mem_req}, 32'd0);
    chk("midfill_rst_rdy", {31'd0, cpu_ready}, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access("rd_after_rst", 1'b0, 32'h240, 32'h0, 1'b0, 32'hF, 32'hF);
`ifdef DATA_CACHE_STATS_EN
    chk("stats_hit", hit_count, 32'd0);
    chk("stats_miss", miss_count, 32'd1);
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("stats_clr_miss", miss_count, 32'd0);
`endif

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_cache_sa.md
Name: data_cache_sa

Overview:
- Parametrised, clocked, N-way set-associative data cache between the processor MEM stage and a word-wide backing memory.
- Write-through, no-write-allocate policy. Per-line valid bits and per-set round-robin replacement.
- Read-miss refill runs over a req/ack handshake, and a single-cycle flush invalidates all lines.
- Requester (MEM stage) stalls until cpu_ready.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width; one word per line
SETS, 8, number of sets; power of two, >=2
WAYS, 2, associativity; power of two, >=1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  invalidate all lines (accepted only in IDLE)
cpu_req  in  1  access request; held with operands stable until cpu_ready
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  byte address (ALU result); bits [1:0] ignored
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
mem_req  out  1  backing-memory request
mem_we  out  1  backing-memory write
mem_addr  out  ADDR_W  word-aligned address to memory
mem_wdata  out  DATA_W  write data to memory
mem_rdata  in  DATA_W  refill data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle

Behaviour:
- Address split: IDX_W=log2(SETS). index=cpu_addr[IDX_W+1:2]; tag=cpu_addr[ADDR_W-1:IDX_W+2].
- Storage per set/way: valid bit, tag, data word. Per set: round-robin victim pointer, log2(WAYS) bits.
- Reset (async):
  - All valid bits, victim pointers, cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr and mem_wdata go to 0.
  - State goes to IDLE.
  - Tag/data contents are undefined.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE, with flush=1:
  - All valid bits and victim pointers clear on the next edge.
  - Any cpu_req in that cycle is not accepted; it is retried in later IDLE cycles.
- IDLE, with cpu_req=1 and flush=0 (acceptance cycle T): tags of all ways in the indexed set are compared, hit = valid && tag equal.
  - Read hit: cpu_rdata <= hit way data; go to DONE. cpu_ready=1 at T+1 (latency 1).
  - Read miss: mem_req<=1, mem_we<=0, mem_addr<={cpu_addr[ADDR_W-1:2],2'b00}; go to FILL.
  - Write, hit or miss: hit way data <= cpu_wdata on hit; a miss does not allocate. mem_req<=1, mem_we<=1, mem_addr aligned, mem_wdata<=cpu_wdata; go to WRITE.
- FILL: mem_req held until mem_ack.
  - On mem_ack, the victim way (pointer value) gets valid=1, the tag and mem_rdata.
  - The pointer increments modulo WAYS; cpu_rdata<=mem_rdata; mem_req<=0; go to DONE.
- WRITE: mem_req/mem_we held until mem_ack. On mem_ack, mem_req<=0, mem_we<=0; go to DONE.
- DONE: cpu_ready=1 for exactly this cycle; nothing is accepted; go to IDLE. cpu_ready is 0 in every other state.
- mem_ack outside FILL/WRITE is ignored. flush outside IDLE is ignored (not queued).
- Replacement: the pointer advances only on fill. Hits do not update it, so replacement is FIFO per set.
- A tag is never present in two ways of one set, because fills occur only on miss.
- cpu_rdata holds its last value outside DONE.
- Reset mid-FILL/WRITE: the transaction is abandoned, mem_req drops asynchronously, and nothing is refilled.

Optional Feature:
- Macro: DATA_CACHE_STATS_EN.
- When defined: adds outputs hit_count[31:0] and miss_count[31:0], plus input stats_clr.
  - Each accepted access increments exactly one counter in its acceptance cycle; writes count by hit/miss too.
  - Counters wrap at 2^32 and reset to 0.
  - stats_clr=1 zeroes both on the next edge and takes priority over an increment in the same cycle.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Read miss then hit, defaults:
   - After reset, read 0x00000040 -> mem_req=1, mem_we=0, mem_addr=0x40.
   - mem_ack with 0xDEADBEEF after 3 cycles -> cpu_ready, cpu_rdata=0xDEADBEEF.
   - Re-read -> cpu_ready at T+1, mem_req stays 0.
2. Write-through hit:
   - Write 0x12345678 to 0x40 (cached) -> mem_req=1, mem_we=1, mem_wdata=0x12345678; ack -> cpu_ready.
   - Read 0x40 -> 0x12345678 with no mem_req.
3. No-write-allocate: write to 0x80 (uncached), then read 0x80 -> miss, mem_req issued.
4. Replacement, WAYS=2:
   - Read 0x40, 0x140, 0x240 (all index 0) with refills 0xA, 0xB, 0xC.
   - Read 0x140 -> hit 0xB. Read 0x40 -> miss (evicted).
5. Flush and priority:
   - After filling 0x40, assert flush together with cpu_req read 0x40 -> not accepted that cycle.
   - Next IDLE cycle -> miss, mem_req=1.
6. Reset mid-fill:
   - Drop rst_n while in FILL -> mem_req=0 immediately, cpu_ready=0.
   - After release, read same address -> miss. With DATA_CACHE_STATS_EN, counts are hit_count=0, miss_count=1.
